// File: rtl/magnitude_pipe.sv
// Streaming gradient magnitude (L1 / alpha-max-beta-min / exact isqrt) with fixed latency WIDTH_P+2 and a global stall.
// Optional threshold compare (thresh_i / edge_o) is built when MAGNITUDE_PIPE_THRESH_EN is defined.
module magnitude_pipe #(
    parameter int WIDTH_P = 8,
    parameter int MAG_W_P = WIDTH_P + 1
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic signed [WIDTH_P-1:0] gx_i,
    input  logic signed [WIDTH_P-1:0] gy_i,
    input  logic        [1:0]         mode_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic        [MAG_W_P-1:0] mag_o,
    output logic        [1:0]         mode_o
`ifdef MAGNITUDE_PIPE_THRESH_EN
    ,
    input  logic        [MAG_W_P-1:0] thresh_i,
    output logic                      edge_o
`endif
);

    localparam int AW   = WIDTH_P + 1;
    localparam int RADW = 2 * WIDTH_P;
    localparam int RW   = WIDTH_P + 4;
    localparam int NS   = WIDTH_P;

    logic               w_adv;
    logic [WIDTH_P-1:0] w_absX;
    logic [WIDTH_P-1:0] w_absY;
    logic [WIDTH_P-1:0] w_mx;
    logic [WIDTH_P-1:0] w_mn;
    logic [AW-1:0]      w_l1;
    logic [AW-1:0]      w_approx;
    logic [AW-1:0]      w_res0;
    logic [RADW-1:0]    w_sqX;
    logic [RADW-1:0]    w_sqY;
    logic [RADW-1:0]    w_rad;
    logic [MAG_W_P-1:0] w_magFinal;

    logic               r_vld  [0:NS];
    logic [1:0]         r_mode [0:NS];
    logic [AW-1:0]      r_res  [0:NS];
    logic [WIDTH_P-1:0] r_root [0:NS];
    logic [RADW-1:0]    r_rad  [0:NS-1];
    logic [RW-1:0]      r_rem  [0:NS-1];

    logic [RW-1:0]      w_tmp      [1:NS];
    logic [RW-1:0]      w_trial    [1:NS];
    logic [RW-1:0]      w_remNext  [1:NS];
    logic [WIDTH_P-1:0] w_rootNext [1:NS];

    assign w_adv   = !valid_o | ready_i;
    assign ready_o = w_adv;

    // Magnitudes fit in WIDTH_P unsigned bits, so the most negative input needs no extra bit.
    assign w_absX   = gx_i[WIDTH_P-1] ? (~gx_i + 1'b1) : gx_i;
    assign w_absY   = gy_i[WIDTH_P-1] ? (~gy_i + 1'b1) : gy_i;
    assign w_mx     = (w_absX >= w_absY) ? w_absX : w_absY;
    assign w_mn     = (w_absX >= w_absY) ? w_absY : w_absX;
    assign w_l1     = {1'b0, w_absX} + {1'b0, w_absY};
    assign w_approx = {1'b0, w_mx} + {1'b0, w_mn >> 2} + {1'b0, w_mn >> 3};
    assign w_res0   = (mode_i == 2'd1) ? w_approx : w_l1;
    assign w_sqX    = RADW'(w_absX) * RADW'(w_absX);
    assign w_sqY    = RADW'(w_absY) * RADW'(w_absY);
    assign w_rad    = w_sqX + w_sqY;

    // Restoring square root: each stage brings down two radicand bits and decides one root bit.
    always_comb begin
        w_tmp      = '{default: '0};
        w_trial    = '{default: '0};
        w_remNext  = '{default: '0};
        w_rootNext = '{default: '0};
        for (int k = 1; k <= NS; k++) begin
            w_tmp[k]   = (r_rem[k-1] << 2) | {{(RW-2){1'b0}}, r_rad[k-1][RADW-1 -: 2]};
            w_trial[k] = {{(RW-WIDTH_P-2){1'b0}}, r_root[k-1], 2'b01};
            if (w_tmp[k] >= w_trial[k]) begin
                w_remNext[k]  = w_tmp[k] - w_trial[k];
                w_rootNext[k] = (r_root[k-1] << 1) | {{(WIDTH_P-1){1'b0}}, 1'b1};
            end else begin
                w_remNext[k]  = w_tmp[k];
                w_rootNext[k] = r_root[k-1] << 1;
            end
        end
    end

    assign w_magFinal = (r_mode[NS] == 2'd2) ? MAG_W_P'(r_root[NS]) : MAG_W_P'(r_res[NS]);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k <= NS; k++) begin
                r_vld[k]  <= 1'b0;
                r_mode[k] <= '0;
                r_res[k]  <= '0;
                r_root[k] <= '0;
            end
            for (int k = 0; k < NS; k++) begin
                r_rad[k] <= '0;
                r_rem[k] <= '0;
            end
            valid_o <= 1'b0;
            mag_o   <= '0;
            mode_o  <= '0;
        end else if (w_adv) begin
            r_vld[0]  <= valid_i;
            r_mode[0] <= mode_i;
            r_res[0]  <= w_res0;
            r_root[0] <= '0;
            r_rad[0]  <= w_rad;
            r_rem[0]  <= '0;
            for (int k = 1; k <= NS; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_mode[k] <= r_mode[k-1];
                r_res[k]  <= r_res[k-1];
                r_root[k] <= w_rootNext[k];
            end
            for (int k = 1; k < NS; k++) begin
                r_rad[k] <= r_rad[k-1] << 2;
                r_rem[k] <= w_remNext[k];
            end
            valid_o <= r_vld[NS];
            mag_o   <= w_magFinal;
            mode_o  <= r_mode[NS];
        end
    end

`ifdef MAGNITUDE_PIPE_THRESH_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            edge_o <= 1'b0;
        end else if (w_adv) begin
            edge_o <= (w_magFinal >= thresh_i);
        end
    end
`endif

endmodule

// File: tb/tb_magnitude_pipe.sv
// Scoreboard bench for magnitude_pipe (WIDTH_P=8): directed vectors, random traffic with backpressure, stall and reset.
// Checks edge_o as well when MAGNITUDE_PIPE_THRESH_EN is defined.
module tb_magnitude_pipe;

    localparam int W   = 8;
    localparam int MW  = W + 1;
    localparam int LAT = W + 2;

    logic                clk_i = 1'b0;
    logic                rstn_i;
    logic                valid_i;
    logic                ready_o;
    logic signed [W-1:0] gx_i;
    logic signed [W-1:0] gy_i;
    logic        [1:0]   mode_i;
    logic                valid_o;
    logic                ready_i;
    logic        [MW-1:0] mag_o;
    logic        [1:0]   mode_o;
`ifdef MAGNITUDE_PIPE_THRESH_EN
    logic        [MW-1:0] thresh_i = MW'(5);
    logic                edge_o;
`endif

    magnitude_pipe #(.WIDTH_P(W), .MAG_W_P(MW)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .gx_i    (gx_i),
        .gy_i    (gy_i),
        .mode_i  (mode_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .mag_o   (mag_o),
        .mode_o  (mode_o)
`ifdef MAGNITUDE_PIPE_THRESH_EN
        ,
        .thresh_i(thresh_i),
        .edge_o  (edge_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int mag;
        int mode;
        int edgeBit;
        int cyc;
    } expBeat_t;

    expBeat_t sbq[$];
    int  checkCount = 0;
    int  errCount   = 0;
    int  cyc        = 0;
    int  directExp  = -1;
    bit  latCheck   = 1'b0;
    bit  drainCheck = 1'b0;
    bit  randReady  = 1'b0;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic int refMag(input int gx, input int gy, input int mode);
        int ax, ay, mx, mn, s, r;
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        mx = (ax > ay) ? ax : ay;
        mn = (ax > ay) ? ay : ax;
        case (mode)
            1: return mx + mn / 4 + mn / 8;
            2: begin
                s = ax * ax + ay * ay;
                r = 0;
                while ((r + 1) * (r + 1) <= s) r++;
                return r;
            end
            default: return ax + ay;
        endcase
    endfunction

    always @(posedge clk_i) cyc++;

    // Push on accept, compare the queue head whenever a result is presented, pop on handshake.
    always @(negedge clk_i) begin
        expBeat_t e;
        if (rstn_i) begin
            if (valid_i && ready_o) begin
                e.mag     = (directExp >= 0) ? directExp : refMag(int'(gx_i), int'(gy_i), int'(mode_i));
                e.mode    = int'(mode_i);
                e.edgeBit = (e.mag >= 5) ? 1 : 0;
                e.cyc     = cyc;
                sbq.push_back(e);
            end
            if (valid_o) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpectedBeat", 1, 0);
                end else begin
                    checkOutput("mag", int'(mag_o), sbq[0].mag);
                    checkOutput("mode", int'(mode_o), sbq[0].mode);
`ifdef MAGNITUDE_PIPE_THRESH_EN
                    checkOutput("edge", int'(edge_o), sbq[0].edgeBit);
`endif
                    if (ready_i) begin
                        if (latCheck) checkOutput("latency", cyc - sbq[0].cyc, LAT);
                        void'(sbq.pop_front());
                    end
                end
            end
            if (drainCheck) checkOutput("drainValid", int'(valid_o), 1);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic applyStimulus(input int gx, input int gy, input int mode, output int cycles);
        bit accepted;
        accepted = 1'b0;
        cycles   = 0;
        gx_i     = W'(gx);
        gy_i     = W'(gy);
        mode_i   = 2'(mode);
        valid_i  = 1'b1;
        while (!accepted && cycles < 1000) begin
            @(negedge clk_i);
            accepted = ready_o;
            @(posedge clk_i);
            #1;
            cycles++;
        end
        valid_i = 1'b0;
        if (!accepted) checkOutput("acceptTimeout", 0, 1);
    endtask

    task automatic applyDirected(input int gx, input int gy, input int mode, input int expMag);
        int c;
        directExp = expMag;
        applyStimulus(gx, gy, mode, c);
        directExp = -1;
    endtask

    task automatic waitDrain();
        int b;
        b = 0;
        while (sbq.size() != 0 && b < 2000) begin
            @(posedge clk_i);
            #1;
            b++;
        end
        if (sbq.size() != 0) checkOutput("drainTimeout", sbq.size(), 0);
    endtask

    task automatic randomBeats(input int n);
        int c;
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 2));
            applyStimulus(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                          int'($urandom_range(0, 3)), c);
        end
        randReady = 1'b0;
    endtask

    task automatic readyToggler();
        while (randReady) begin
            @(posedge clk_i);
            #1;
            ready_i = ($urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        gx_i    = '0;
        gy_i    = '0;
        mode_i  = '0;
        #3;
        checkOutput("rstValid", int'(valid_o), 0);
        checkOutput("rstReady", int'(ready_o), 1);
        checkOutput("rstMag", int'(mag_o), 0);
        checkOutput("rstMode", int'(mode_o), 0);
        @(posedge clk_i);
        #2;
        rstn_i = 1'b1;
        idle(2);
        checkOutput("postRstReady", int'(ready_o), 1);

        // Directed vectors back-to-back with constant expectations and exact latency.
        latCheck = 1'b1;
        applyDirected(3, -4, 0, 7);
        applyDirected(3, -4, 1, 4);
        applyDirected(3, -4, 2, 5);
        applyDirected(-128, -128, 0, 256);
        applyDirected(-128, -128, 1, 176);
        applyDirected(-128, -128, 2, 181);
        applyDirected(0, 0, 0, 0);
        applyDirected(0, 0, 1, 0);
        applyDirected(0, 0, 2, 0);
        applyDirected(0, 0, 3, 0);
        applyDirected(127, 0, 2, 127);
        applyDirected(2, 2, 2, 2);
        applyDirected(-128, 127, 3, 255);
        waitDrain();
        latCheck = 1'b0;

        // Random traffic under random backpressure.
        randReady = 1'b1;
        fork
            randomBeats(200);
            readyToggler();
        join
        ready_i = 1'b1;
        waitDrain();

        // Fill the pipe against a stalled sink, then release at full rate.
        ready_i = 1'b0;
        for (int i = 0; i < LAT; i++)
            applyStimulus(i * 11 - 60, 40 - i * 9, i % 4, c);
        gx_i    = 8'sd17;
        gy_i    = -8'sd33;
        mode_i  = 2'd2;
        valid_i = 1'b1;
        idle(20);
        checkOutput("stallReady", int'(ready_o), 0);
        checkOutput("stallValid", int'(valid_o), 1);
        checkOutput("stallDepth", sbq.size(), LAT);
        ready_i    = 1'b1;
        drainCheck = 1'b1;
        applyStimulus(17, -33, 2, c);
        checkOutput("releaseAccept", c, 1);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(i * 7 - 50, i * 5 - 30, (i + 1) % 4, c);
            checkOutput("throughput", c, 1);
        end
        drainCheck = 1'b0;
        waitDrain();

        // Asynchronous reset with six beats in flight.
        for (int i = 0; i < 12; i++)
            applyStimulus(5, 7, 2, c);
        idle(4);
        checkOutput("inFlight", sbq.size(), 6);
        checkOutput("preRstValid", int'(valid_o), 1);
        #2;
        rstn_i = 1'b0;
        #1;
        checkOutput("asyncRstValid", int'(valid_o), 0);
        checkOutput("asyncRstMag", int'(mag_o), 0);
        checkOutput("asyncRstMode", int'(mode_o), 0);
        checkOutput("asyncRstReady", int'(ready_o), 1);
        sbq.delete();
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        rstn_i = 1'b1;
        idle(1);
        applyDirected(1, 1, 0, 2);
        applyDirected(-6, 8, 2, 10);
        applyDirected(-100, 40, 1, 115);
        waitDrain();
        idle(LAT + 5);
        checkOutput("finalQueue", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/magnitude_pipe.md
Name: magnitude_pipe

Overview:
- Streaming gradient-magnitude unit for the Sobel datapath; sits between the signed gx/gy convolution stage and thresholding/NMS.
- Generalises the existing single-mode magnitude block in four ways: signed inputs of parametrised width, a per-beat mode select (L1, alpha-max-beta-min, exact integer sqrt), a fixed-latency fully pipelined datapath with no LUT, and a single global stall for ready/valid backpressure.

Parameters:
- WIDTH_P, 8: width of signed two's-complement gx/gy inputs; legal range 4..16.
- MAG_W_P, WIDTH_P+1: output magnitude width; must be >= WIDTH_P+1; result is zero-extended to this width.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input beat valid.
- ready_o  out  1  unit can accept a beat this cycle.
- gx_i  in  WIDTH_P  signed horizontal gradient.
- gy_i  in  WIDTH_P  signed vertical gradient.
- mode_i  in  2  per-beat mode: 0 = L1, 1 = approx, 2 = exact sqrt, 3 = reserved (computed as L1).
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts the output beat.
- mag_o  out  MAG_W_P  magnitude result.
- mode_o  out  2  mode tag travelling with the beat.

Behaviour:
- Pipeline of L = WIDTH_P+2 register stages: S0 (abs/square/L1/approx), S1..S_WIDTH_P (one sqrt result bit per stage, MSB first, restoring method), S_out (output register).
- Each stage carries a valid bit, the mode tag, the L1/approx result and the sqrt remainder/root state. Bubbles propagate as valid=0 and are never presented on valid_o.
- Global advance enable: adv = !valid_o | ready_i. ready_o = adv, a combinational path from ready_i.
- When adv=1, every stage shifts by one. When adv=0, every stage holds, including mag_o, mode_o and valid_o.
- A beat is accepted when valid_i & ready_o. With no stalls, its result appears on valid_o exactly L cycles later. Input-to-output order is strictly preserved.
- |g| is computed at WIDTH_P+1 bits without overflow, so |-2^(WIDTH_P-1)| = 2^(WIDTH_P-1).
- L1: |gx| + |gy|, up to 2^WIDTH_P.
- Approx: mx + (mn>>2) + (mn>>3), where mx = max(|gx|,|gy|) and mn = min. Truncated shifts; no rounding.
- Exact: floor(sqrt(gx^2 + gy^2)). The radicand is 2*WIDTH_P bits unsigned; the root is WIDTH_P bits.
- Modes 0, 1 and 3 take the same latency L as mode 2; their result is delayed through the sqrt stages.
- mode_i is sampled only on accept; mode changes between beats are legal with no flush.
- The result is zero-extended to MAG_W_P. No saturation is needed because all mode results fit in WIDTH_P+1 bits.
- Reset (asynchronous assert, synchronous-safe deassert by the system): all stage valid bits = 0, valid_o = 0, mag_o = 0, mode_o = 0, all datapath registers = 0.
- Reset mid-stream discards every in-flight beat; no partial beat emerges after release.
- ready_o = 1 during and immediately after reset (valid_o = 0).
- Full pipeline with ready_i = 0: ready_o = 0 and the input is not consumed, so the upstream must hold gx_i, gy_i and mode_i.
- Simultaneous ready_i rise and valid_i: accept and emit in the same cycle, giving full throughput of 1 beat/cycle.

Optional Feature:
- Macro MAGNITUDE_PIPE_THRESH_EN.
- When defined, the block adds input thresh_i (MAG_W_P bits, quasi-static) and output edge_o (1 bit).
  - edge_o is registered in S_out alongside mag_o: edge_o = (final magnitude >= thresh_i).
  - edge_o has the same valid/hold semantics as mag_o and resets to 0.
- When undefined, thresh_i and edge_o do not exist and there is no compare logic. All other behaviour is identical.

Test Plan:
- WIDTH_P=8. Beat gx=3, gy=-4 in each of modes 0/1/2, with ready_i=1 held -> mag_o = 7 / 4 / 5 respectively. Each result arrives on valid_o exactly 10 cycles after its accept; mode_o matches each beat.
- gx=-128, gy=-128 -> mode0 256, mode1 176, mode2 181. Also gx=0, gy=0 in all modes -> 0. Also gx=127, gy=0 in mode2 -> 127.
- 200 random beats, random modes, random valid_i gaps, ready_i random ~50% -> scoreboard matches a reference model in order; no drops or duplicates; mag_o/mode_o stable while valid_o & !ready_i.
- Fill pipeline, then hold ready_i=0 for 20 cycles -> ready_o=0, exactly 10 buffered beats. Then release ready_i -> 10 results drain back-to-back, followed by new accepts at 1 beat/cycle.
- Assert rstn_i low asynchronously (off clock edge) with 6 beats in flight -> valid_o, mag_o and mode_o go to 0 immediately. After release, only beats accepted post-reset appear.
- With MAGNITUDE_PIPE_THRESH_EN and thresh_i=5: beats (3,-4) mode2 and (2,2) mode2 -> edge_o = 1 and 0 respectively. Rebuild without the macro -> compiles with the ports absent.
